multi_button_debouncer: RTL and testbench
=========================================

MULTI_BUTTON_DEBOUNCER -- requirements
Module: multi_button_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels (1..16).
REQ-002 Parameter SAMPLE_DIV, default 256: clocks per history sample tick (>=2).
REQ-003 Parameter HIST_LEN, default 8: majority-vote history depth per channel (3..16).
REQ-004 Parameter VOTE_THRESH, default 6: ones needed to vote high; legal range HIST_LEN/2 < VOTE_THRESH <= HIST_LEN.
REQ-005 Parameter DEBOUNCE_CYC, default 4800000: clocks the filtered level must persist before it becomes stable (>=1).
REQ-006 Parameter LONG_CYC, default 96000000: clocks of stable-high hold before a long-press event (>=1).
REQ-007 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 Port rst_n, input, 1: synchronous active-low reset.
REQ-009 Port btn_raw, input, N_CH: asynchronous raw button levels, active-high.
REQ-010 Port btn_stable, output, N_CH: debounced level per channel.
REQ-011 Port press_pulse, output, N_CH: one-cycle pulse on stable 0->1.
REQ-012 Port release_pulse, output, N_CH: one-cycle pulse on stable 1->0.
REQ-013 Port long_pulse, output, N_CH: one-cycle pulse when the hold reaches LONG_CYC (present only with the macro of REQ-029).

Function
REQ-014 Each channel SHALL pass btn_raw through a 3-flop synchronizer; sync3 lags btn_raw by 3 clocks.
REQ-015 One shared prescaler SHALL count 0..SAMPLE_DIV-1 and wrap; tick is high in the cycle the count equals SAMPLE_DIV-1.
REQ-016 On tick, each history register SHALL shift left, inserting sync3 at bit 0; with no tick it holds.
REQ-017 Registered filt SHALL be set when popcount(history) >= VOTE_THRESH, cleared when popcount <= HIST_LEN-VOTE_THRESH, else held (hysteresis).
REQ-018 Per-channel debounce counter: filt == btn_stable -> counter cleared; else counter == DEBOUNCE_CYC-1 -> btn_stable <= filt and counter cleared; else counter increments.
REQ-019 Any cycle with filt equal to btn_stable SHALL restart qualification from zero (glitch abandons progress).
REQ-020 press_pulse/release_pulse SHALL be registered, asserting in the cycle after btn_stable changes, for exactly one cycle.
REQ-021 The hold counter SHALL increment while btn_stable is 1, saturate at LONG_CYC, and clear when btn_stable is 0.
REQ-022 long_pulse SHALL assert for exactly one cycle when the hold counter transitions to LONG_CYC; at most once per press.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-024 Counter widths SHALL be $clog2 of their maximum value +1; no counter may wrap.

Reset
REQ-025 While rst_n is 0 at a clk edge, synchronizers, history, filt, btn_stable, all counters and all pulse outputs SHALL be 0.
REQ-026 Reset mid-press SHALL abandon it silently; no release_pulse is produced by reset itself.
REQ-027 After rst_n rises, a button held high SHALL produce press_pulse only after full synchronization, voting and DEBOUNCE_CYC qualification.
REQ-028 The prescaler SHALL restart from 0 at reset release, making tick timing deterministic.

Configuration
REQ-029 Macro DEBOUNCE_LONGPRESS_EN defined: hold counters and the long_pulse port exist per REQ-021/022.
REQ-030 Macro undefined: long_pulse port, hold counters and associated logic SHALL be absent; all other behaviour unchanged.

Verification (N_CH=4, SAMPLE_DIV=4, HIST_LEN=8, VOTE_THRESH=6, DEBOUNCE_CYC=10, LONG_CYC=50)
REQ-031 Clean press: ch0 held high from reset release -> btn_stable[0]=1 and one press_pulse[0] within 3+6*4+2+10+1 clocks; other channels silent.
REQ-032 Bounce: ch1 toggles every 5 clocks for 200 clocks, then held low -> no press or release pulses, btn_stable[1]=0 throughout.
REQ-033 Hysteresis: history at exactly 5 ones after stable high -> filt and btn_stable stay 1; at 2 ones -> release after 10 clocks.
REQ-034 Long press: ch2 held 200 clocks (macro defined) -> exactly one long_pulse[2], 50 clocks after press_pulse[2]; release_pulse[2] follows release.
REQ-035 Simultaneous: ch0 and ch3 released on the same clock -> release_pulse[0] and [3] in the same cycle.
REQ-036 Reset mid-press: rst_n low for 1 clock while btn_stable[1]=1 -> all outputs 0 next cycle, no release_pulse, re-press reported after full qualification.

Source files
------------

// File: rtl/multi_button_debouncer.sv
// Multi-channel button debouncer: 3-flop sync, majority-vote history filter, debounce qualification, edge pulses.
// Define DEBOUNCE_LONGPRESS_EN to add per-channel hold counters and the long_pulse output.
module multi_button_debouncer #(
  parameter int N_CH         = 4,
  parameter int SAMPLE_DIV   = 256,
  parameter int HIST_LEN     = 8,
  parameter int VOTE_THRESH  = 6,
  parameter int DEBOUNCE_CYC = 4800000,
  parameter int LONG_CYC     = 96000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_stable,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse
`ifdef DEBOUNCE_LONGPRESS_EN
  ,
  output logic [N_CH-1:0] long_pulse
`endif
);

  localparam int PRE_W = $clog2(SAMPLE_DIV - 1) + 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYC - 1) + 1;
  localparam int CNT_W = $clog2(HIST_LEN) + 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LVL  = CNT_W'(VOTE_THRESH);
  localparam logic [CNT_W-1:0] CLR_LVL  = CNT_W'(HIST_LEN - VOTE_THRESH);

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYC) + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYC - 1);
`else
  // Without long-press support a held button only ever yields press/release events.
`endif

  if (N_CH < 1 || N_CH > 16 || SAMPLE_DIV < 2 || HIST_LEN < 3 || HIST_LEN > 16 ||
      VOTE_THRESH <= HIST_LEN / 2 || VOTE_THRESH > HIST_LEN ||
      DEBOUNCE_CYC < 1 || LONG_CYC < 1) begin : g_bad_params
    $error("multi_button_debouncer: illegal parameter set");
  end

  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic [N_CH-1:0]  sync3;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Shared sample-rate prescaler; restarting at reset keeps tick phase deterministic.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [HIST_LEN-1:0] hist;
    logic [CNT_W-1:0]    ones;
    logic                filt;
    logic                stable;
    logic                press_q;
    logic                release_q;
    logic [DEB_W-1:0]    deb_cnt;

    always_comb begin
      ones = '0;
      for (int b = 0; b < HIST_LEN; b++) begin
        ones = ones + CNT_W'(hist[b]);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hist      <= '0;
        filt      <= 1'b0;
        stable    <= 1'b0;
        deb_cnt   <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (tick) begin
          hist <= {hist[HIST_LEN-2:0], sync3[ch]};
        end
        // Vote counts between the two levels leave filt untouched (hysteresis band).
        if (ones >= SET_LVL) begin
          filt <= 1'b1;
        end else if (ones <= CLR_LVL) begin
          filt <= 1'b0;
        end
        // Any agreement between filt and stable throws away partial qualification.
        if (filt == stable) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_cnt   <= '0;
          stable    <= filt;
          press_q   <= filt;
          release_q <= ~filt;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end
    end

    assign btn_stable[ch]    = stable;
    assign press_pulse[ch]   = press_q;
    assign release_pulse[ch] = release_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_q;

    // Saturating at HOLD_MAX means the long event can fire only once per press.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hold_cnt <= '0;
        long_q   <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (!stable) begin
          hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_PRE) begin
            long_q <= 1'b1;
          end
        end
      end
    end

    assign long_pulse[ch] = long_q;
`endif
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed self-checking bench for multi_button_debouncer with small timing parameters.
// Cycle numbers count negedges after reset release; pulses are logged per channel and compared afterwards.
module tb_multi_button_debouncer;
  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] btn_stable;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
`ifdef DEBOUNCE_LONGPRESS_EN
  logic [N_CH-1:0] long_pulse;
  int              long_cnt [N_CH];
  int              long_at  [N_CH];
`endif

  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              press_cnt   [N_CH];
  int              release_cnt [N_CH];
  int              press_at    [N_CH];
  int              release_at  [N_CH];
  logic [N_CH-1:0] stable_or;

  multi_button_debouncer #(
    .N_CH(4), .SAMPLE_DIV(4), .HIST_LEN(8), .VOTE_THRESH(6),
    .DEBOUNCE_CYC(10), .LONG_CYC(50)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_stable    (btn_stable),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
`ifdef DEBOUNCE_LONGPRESS_EN
    ,
    .long_pulse    (long_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    for (int c = 0; c < N_CH; c++) begin
      press_cnt[c]   = 0;
      release_cnt[c] = 0;
      press_at[c]    = -1;
      release_at[c]  = -1;
`ifdef DEBOUNCE_LONGPRESS_EN
      long_cnt[c]    = 0;
      long_at[c]     = -1;
`endif
    end
    stable_or = '0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < N_CH; c++) begin
      if (press_pulse[c] === 1'b1) begin
        press_cnt[c]++;
        if (press_at[c] < 0) press_at[c] = cyc;
      end
      if (release_pulse[c] === 1'b1) begin
        release_cnt[c]++;
        if (release_at[c] < 0) release_at[c] = cyc;
      end
`ifdef DEBOUNCE_LONGPRESS_EN
      if (long_pulse[c] === 1'b1) begin
        long_cnt[c]++;
        if (long_at[c] < 0) long_at[c] = cyc;
      end
`endif
    end
    stable_or = stable_or | btn_stable;
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  // Leaves the bench at negedge 0 with rst_n high and btn_raw = v; the next posedge is the first live edge.
  task automatic start(input logic [N_CH-1:0] v);
    rst_n   = 1'b0;
    btn_raw = v;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    clear_log();
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_stable",  32'(btn_stable),    0);
    check("reset_press",   32'(press_pulse),   0);
    check("reset_release", 32'(release_pulse), 0);
`ifdef DEBOUNCE_LONGPRESS_EN
    check("reset_long",    32'(long_pulse),    0);
`endif

    // Clean press on ch0 held from reset release.
    start(4'b0001);
    run_to(34);
    check("clean_stable_before", 32'(btn_stable), 0);
    run_to(40);
    check("clean_press_cycle",  press_at[0], 35);
    check("clean_press_count",  press_cnt[0], 1);
    check("clean_other_press",  press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    check("clean_release",      release_cnt[0] + release_cnt[1] + release_cnt[2] + release_cnt[3], 0);
    check("clean_stable_after", 32'(btn_stable), 1);

    // Bouncing ch1: 50% duty at period 10 never reaches 6 of 8 votes.
    start(4'b0010);
    for (int i = 1; i <= 200; i++) begin
      step();
      if (i % 5 == 0) btn_raw[1] = ~btn_raw[1];
    end
    btn_raw[1] = 1'b0;
    run_to(260);
    check("bounce_press",   press_cnt[1], 0);
    check("bounce_release", release_cnt[1], 0);
    check("bounce_stable",  32'(stable_or), 0);

    // Hysteresis: dip to 5 ones holds the level, drop to 2 ones releases 10 clocks later.
    start(4'b0001);
    run_to(40);
    btn_raw[0] = 1'b0;
    run_to(50);
    btn_raw[0] = 1'b1;
    run_to(100);
    check("hyst5_stable",  32'(btn_stable[0]), 1);
    check("hyst5_release", release_cnt[0], 0);
    btn_raw[0] = 1'b0;
    run_to(134);
    check("hyst2_stable_before", 32'(btn_stable[0]), 1);
    run_to(140);
    check("hyst2_release_cycle", release_at[0], 135);
    check("hyst2_release_count", release_cnt[0], 1);
    check("hyst2_stable_after",  32'(btn_stable[0]), 0);

    // Long press on ch2 held for 200 clocks.
    start(4'b0100);
    run_to(200);
    btn_raw[2] = 1'b0;
    run_to(245);
    check("long_press_cycle",   press_at[2], 35);
    check("long_press_count",   press_cnt[2], 1);
    check("long_release_cycle", release_at[2], 235);
    check("long_release_count", release_cnt[2], 1);
`ifdef DEBOUNCE_LONGPRESS_EN
    check("long_pulse_cycle", long_at[2], 85);
    check("long_pulse_count", long_cnt[2], 1);
    check("long_pulse_other", long_cnt[0] + long_cnt[1] + long_cnt[3], 0);
`endif

    // Simultaneous press and release on ch0 and ch3.
    start(4'b1001);
    run_to(60);
    btn_raw = 4'b0000;
    run_to(100);
    check("simul_press0",   press_at[0], 35);
    check("simul_press3",   press_at[3], 35);
    check("simul_release0", release_at[0], 95);
    check("simul_release3", release_at[3], 95);
    check("simul_other",    press_cnt[1] + press_cnt[2] + release_cnt[1] + release_cnt[2], 0);

    // Reset for one clock while ch1 is stable high, then full requalification.
    start(4'b0010);
    run_to(50);
    check("rstmid_stable_pre", 32'(btn_stable), 2);
    rst_n = 1'b0;
    step();
    check("rstmid_stable",  32'(btn_stable), 0);
    check("rstmid_press",   32'(press_pulse), 0);
    check("rstmid_release", release_cnt[1], 0);
    rst_n = 1'b1;
    clear_log();
    run_to(85);
    check("rstmid_stable_wait", 32'(btn_stable[1]), 0);
    run_to(95);
    check("rstmid_repress_cycle", press_at[1], 86);
    check("rstmid_repress_count", press_cnt[1], 1);
    check("rstmid_no_release",    release_cnt[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
